// File: rtl/deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_if
// Description : Bus bundle between the serial bit source / frame consumer
//               and the deserializer.
//               slave  modport : deserializer side
//               master modport : source/consumer side
//               iData_in / iData_valid : serial bit and its one-beat qualifier
//               iAck                   : consumer release/abort of the frame
//               oData_out / oCounter   : assembled word and captured bit count
//               oFull / oOverflow      : frame complete / beat dropped in FULL
// Revision    : 1.0 - initial release
// ============================================================================
interface deserializer_if #(
    parameter int MSG_SIZE = 64
);
    localparam int CW = $clog2(MSG_SIZE) + 1;

    logic                iData_in;
    logic                iData_valid;
    logic                iAck;
    logic [MSG_SIZE-1:0] oData_out;
    logic [CW-1:0]       oCounter;
    logic                oFull;
    logic                oOverflow;

    modport slave (
        input  iData_in, iData_valid, iAck,
        output oData_out, oCounter, oFull, oOverflow
    );

    modport master (
        output iData_in, iData_valid, iAck,
        input  oData_out, oCounter, oFull, oOverflow
    );
endinterface
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : MSB-first serial-to-parallel front end. Shifts in one bit per
//               valid beat until MSG_SIZE bits are assembled, then holds the
//               word and count (== MSG_SIZE) until the consumer acknowledges.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset, overrides ena
//               ena  - block enable, low freezes all state
//               bus  - deserializer_if.slave (serial input, ack, outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer #(
    parameter int MSG_SIZE = 64
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 ena,
    deserializer_if.slave       bus
);
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(MSG_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic [MSG_SIZE-1:0] r_data;
    logic [CW-1:0]       r_count;
    logic                r_full;
    logic                r_ovf;

    state_t              w_state_nxt;
    logic [MSG_SIZE-1:0] w_data_nxt;
    logic [CW-1:0]       w_count_nxt;
    logic                w_ovf_nxt;
    logic [CW-1:0]       w_count_inc;

    assign w_count_inc = r_count + CW'(1);

    // State register: rst overrides everything, ena=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
            // oFull is registered from the next state so it rises on the
            // same edge that the count reaches MSG_SIZE.
            r_full  <= (w_state_nxt == S_FULL);
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state logic. iAck has priority over a coincident beat, so an
    // abort never captures the bit and never flags an overflow.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;

        if (bus.iAck) begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (bus.iData_valid) begin
            case (r_state)
                S_FULL: begin
                    // Frame is held; the beat is dropped and remembered.
                    w_ovf_nxt = 1'b1;
                end
                default: begin
                    w_data_nxt  = {r_data[MSG_SIZE-2:0], bus.iData_in};
                    w_count_nxt = w_count_inc;
                    w_state_nxt = (w_count_inc == c_FULL_COUNT) ? S_FULL
                                                                : S_SHIFT;
                end
            endcase
        end
    end

    assign bus.oData_out = r_data;
    assign bus.oCounter  = r_count;
    assign bus.oFull     = r_full;
    assign bus.oOverflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer. A bit-queue reference
//               model predicts the outputs after every clock edge; the
//               prediction is queued and a separate monitor compares it with
//               the DUT half a cycle later. Directed scenarios add explicit
//               checks against known words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;
    localparam int MSG = 64;
    localparam int CW  = $clog2(MSG) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;

    deserializer_if #(.MSG_SIZE(MSG)) bus ();

    deserializer #(.MSG_SIZE(MSG)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MSG-1:0] d;
        logic [CW-1:0]  c;
        logic           f;
        logic           o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the captured bits in arrival order plus a sticky flag.
    bit mq[$];
    bit movf;

    function automatic exp_t model_out();
        exp_t e;
        e.d = '0;
        foreach (mq[i]) e.d = {e.d[MSG-2:0], mq[i]};
        e.c = CW'(mq.size());
        e.f = (mq.size() == MSG);
        e.o = movf;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit v,
                              input bit dd, input bit a);
        if (r) begin
            mq.delete();
            movf = 1'b0;
        end else if (e) begin
            if (a) begin
                mq.delete();
                movf = 1'b0;
            end else if (v) begin
                if (mq.size() == MSG) movf = 1'b1;
                else                  mq.push_back(dd);
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic cyc(input bit r, input bit e, input bit v,
                       input bit dd, input bit a);
        rst             = r;
        ena             = e;
        bus.iData_valid = v;
        bus.iData_in    = dd;
        bus.iAck        = a;
        @(posedge clk);
        model_step(r, e, v, dd, a);
        sb.push_back(model_out());
        #1;
    endtask

    // Monitor: compare every predicted output set away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (bus.oData_out !== e.d || bus.oCounter !== e.c ||
                bus.oFull !== e.f || bus.oOverflow !== e.o) begin
                bad++;
                $display("FAIL monitor t=%0t got d=%h c=%0d f=%b o=%b want d=%h c=%0d f=%b o=%b",
                         $time, bus.oData_out, bus.oCounter, bus.oFull,
                         bus.oOverflow, e.d, e.c, e.f, e.o);
            end
        end
    end

    task automatic chk(input string name, input logic [MSG-1:0] act,
                       input logic [MSG-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Send n bits of w, MSB-first, starting at bit position 'start' (0 = MSB),
    // with 0..maxgap idle cycles before each beat.
    task automatic send_bits(input logic [MSG-1:0] w, input int start,
                             input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) cyc(0, 1, 0, 1'($urandom), 0);
            cyc(0, 1, 1, w[MSG-1-(start+i)], 0);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data"}, bus.oData_out, '0);
        chk({name, "_cnt"},  MSG'(bus.oCounter), '0);
        chk({name, "_full"}, MSG'(bus.oFull), '0);
        chk({name, "_ovf"},  MSG'(bus.oOverflow), '0);
    endtask

    logic [MSG-1:0] W1;
    logic [MSG-1:0] W2;

    initial begin
        W1 = 64'hDEADBEEF01234567;
        W2 = 64'hFFFF0000AAAA5555;
        bus.iData_in    = 1'b0;
        bus.iData_valid = 1'b0;
        bus.iAck        = 1'b0;
        movf            = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        chk_zero("reset");

        // 1: back-to-back frame
        send_bits(W1, 0, 63, 0);
        chk("t1_cnt63",  MSG'(bus.oCounter), 63);
        chk("t1_full63", MSG'(bus.oFull), 0);
        send_bits(W1, 63, 1, 0);
        chk("t1_data", bus.oData_out, W1);
        chk("t1_cnt",  MSG'(bus.oCounter), 64);
        chk("t1_full", MSG'(bus.oFull), 1);
        chk("t1_ovf",  MSG'(bus.oOverflow), 0);

        // 2: same word with random gaps
        cyc(0, 1, 0, 0, 1);
        send_bits(W1, 0, 64, 3);
        chk("t2_data", bus.oData_out, W1);
        chk("t2_full", MSG'(bus.oFull), 1);

        // 3: overflow in FULL, then ack
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        chk("t3_ovf",  MSG'(bus.oOverflow), 1);
        chk("t3_data", bus.oData_out, W1);
        chk("t3_cnt",  MSG'(bus.oCounter), 64);
        cyc(0, 1, 0, 0, 1);
        chk_zero("t3_ack");

        // 4: abort partial frame with ack+valid, then clean frame
        send_bits(W2 ^ W1, 0, 10, 0);
        chk("t4_cnt10", MSG'(bus.oCounter), 10);
        cyc(0, 1, 1, 1, 1);
        chk_zero("t4_abort");
        send_bits(W2, 0, 64, 0);
        chk("t4_data", bus.oData_out, W2);
        chk("t4_full", MSG'(bus.oFull), 1);

        // 5: ena=0 freezes mid-frame
        cyc(0, 1, 0, 0, 1);
        send_bits(W1, 0, 20, 1);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 1);
        chk("t5_cnt_frozen", MSG'(bus.oCounter), 20);
        send_bits(W1, 20, 44, 1);
        chk("t5_data", bus.oData_out, W1);
        chk("t5_full", MSG'(bus.oFull), 1);

        // 6: reset overrides ena=0, and clears FULL+overflow
        cyc(0, 1, 0, 0, 1);
        send_bits(W2, 0, 30, 0);
        chk("t6_cnt30", MSG'(bus.oCounter), 30);
        cyc(1, 0, 0, 0, 0);
        chk_zero("t6_rst_dis");
        send_bits(W2, 0, 64, 0);
        cyc(0, 1, 1, 0, 0);
        chk("t6_ovf", MSG'(bus.oOverflow), 1);
        cyc(1, 1, 1, 1, 0);
        chk_zero("t6_rst_full");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit e, v, a, r;
            e = ($urandom_range(9, 0) != 0);
            v = ($urandom_range(3, 0) != 0);
            a = ($urandom_range(99, 0) < 2);
            r = ($urandom_range(499, 0) == 0);
            cyc(r, e, v, 1'($urandom), a);
        end

        cyc(0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
